// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// states, opcode/funct values, instruction classes and mux select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_SHIFT, C_JR, C_JALR, C_BEQ, C_J,
        C_JAL, C_IARITH, C_LW, C_SW, C_ILLEGAL
    } class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_A     = 2'b01;
    localparam logic [1:0] SA_SHAMT = 2'b10;

    localparam logic [1:0] SB_B     = 2'b00;
    localparam logic [1:0] SB_FOUR  = 2'b01;
    localparam logic [1:0] SB_IMM   = 2'b10;
    localparam logic [1:0] SB_IMMSH = 2'b11;

    localparam logic [1:0] AOP_ADD = 2'b00;
    localparam logic [1:0] AOP_SUB = 2'b01;
    localparam logic [1:0] AOP_FN  = 2'b10;
    localparam logic [1:0] AOP_OP  = 2'b11;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP = 2'b10;
    localparam logic [1:0] PCS_REG  = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Instruction class decoder: latched OpCode/Funct -> execution class,
// plus immediate extension controls.
module mc_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output class_e     cls_o,
    output logic       ext_op_o,
    output logic       lu_op_o
);

    // Map opcode (and funct for R-type) onto one execution class
    always_comb begin
        cls_o = C_ILLEGAL;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_SLL, FN_SRL, FN_SRA: cls_o = C_SHIFT;
                    FN_JR:                  cls_o = C_JR;
                    FN_JALR:                cls_o = C_JALR;
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU:        cls_o = C_R;
                    default:                cls_o = C_ILLEGAL;
                endcase
            end
            OP_J:   cls_o = C_J;
            OP_JAL: cls_o = C_JAL;
            OP_BEQ: cls_o = C_BEQ;
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_SLTIU, OP_ANDI, OP_LUI: cls_o = C_IARITH;
            OP_LW:  cls_o = C_LW;
            OP_SW:  cls_o = C_SW;
            default: cls_o = C_ILLEGAL;
        endcase
    end

    assign ext_op_o = (op_i != OP_ANDI);
    assign lu_op_o  = (op_i == OP_LUI);

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS sequencer: state register, memory wait timeout,
// sticky error flags and the per-state datapath control table.
module multi_cycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       ExtOp,
    output logic       LuOp,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_error
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST =
        CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q;
    logic          illegal_q, bus_q;
    class_e        cls;
    logic          ext_op, lu_op;
    logic          mem_wait, timeout, set_ill;

    mc_decode u_dec (
        .op_i     (OpCode),
        .funct_i  (Funct),
        .cls_o    (cls),
        .ext_op_o (ext_op),
        .lu_op_o  (lu_op)
    );

    assign mem_wait = (state_q == S_IF) || (state_q == S_MEM);
    assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && !mem_ready
                      && (wait_q == TO_LAST);
    assign set_ill  = (state_q == S_ID) && (cls == C_ILLEGAL);

    // Next-state selection; a timed-out access abandons the instruction
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                case (cls)
                    C_J, C_JAL, C_ILLEGAL: state_d = S_IF;
                    default:               state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (cls)
                    C_R, C_SHIFT, C_IARITH: state_d = S_WB;
                    C_LW, C_SW:             state_d = S_MEM;
                    default:                state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (mem_ready)
                    state_d = (cls == C_LW) ? S_WB : S_IF;
                else if (timeout)
                    state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // State register, wait counter and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IF;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || timeout)
                wait_q <= '0;
            else if (mem_wait && MEM_TIMEOUT != 0)
                wait_q <= wait_q + 1'b1;
            if (set_ill) illegal_q <= 1'b1;
            if (timeout) bus_q <= 1'b1;
        end
    end

    // Control table: strobes and selects from state and instruction class
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = RD_RT;
        MemtoReg    = M2R_ALU;
        ALUSrcA     = SA_PC;
        ALUSrcB     = SB_B;
        ALUOp       = AOP_ADD;
        PCSource    = PCS_ALU;
        instr_done  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    MemRead = 1'b1;
                    ALUSrcB = SB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_ID: begin
                    ALUSrcB = SB_IMMSH;
                    if (cls == C_J || cls == C_JAL) begin
                        PCWrite    = 1'b1;
                        PCSource   = PCS_JUMP;
                        instr_done = 1'b1;
                    end
                    if (cls == C_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RA;
                        MemtoReg = M2R_PC;
                    end
                end
                S_EX: begin
                    case (cls)
                        C_R, C_SHIFT: begin
                            ALUSrcA = (cls == C_SHIFT) ? SA_SHAMT : SA_A;
                            ALUOp   = AOP_FN;
                        end
                        C_JR, C_JALR: begin
                            PCWrite    = 1'b1;
                            PCSource   = PCS_REG;
                            instr_done = 1'b1;
                            if (cls == C_JALR) begin
                                RegWrite = 1'b1;
                                RegDst   = RD_RD;
                                MemtoReg = M2R_PC;
                            end
                        end
                        C_BEQ: begin
                            ALUSrcA     = SA_A;
                            ALUOp       = AOP_SUB;
                            PCWriteCond = 1'b1;
                            PCSource    = PCS_OUT;
                            instr_done  = 1'b1;
                        end
                        C_IARITH: begin
                            ALUSrcA = SA_A;
                            ALUSrcB = SB_IMM;
                            ALUOp   = AOP_OP;
                        end
                        C_LW, C_SW: begin
                            ALUSrcA = SA_A;
                            ALUSrcB = SB_IMM;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    IorD       = 1'b1;
                    MemRead    = (cls == C_LW);
                    MemWrite   = (cls == C_SW);
                    instr_done = (cls == C_SW) && mem_ready;
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    RegDst     = (cls == C_LW || cls == C_IARITH) ? RD_RT : RD_RD;
                    MemtoReg   = (cls == C_LW) ? M2R_MDR : M2R_ALU;
                end
                default: ;
            endcase
        end
    end

    assign ExtOp      = !reset && ext_op;
    assign LuOp       = !reset && lu_op;
    assign state      = state_q;
    assign illegal_op = illegal_q;
    assign bus_error  = bus_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized check of the multi-cycle controller against a
// per-instruction phase model built from the instruction kind.
module tb_multi_cycle_controller;

    localparam int TO = 16;

    localparam int K_R = 0, K_SH = 1, K_JR = 2, K_JALR = 3, K_BEQ = 4, K_J = 5;
    localparam int K_JAL = 6, K_IA = 7, K_LW = 8, K_SW = 9, K_BAD = 10;

    localparam logic [2:0] P_IF = 3'd0, P_ID = 3'd1, P_EX = 3'd2;
    localparam logic [2:0] P_MEM = 3'd3, P_WB = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource;
    logic       ExtOp, LuOp, instr_done, illegal_op, bus_error;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    int cur_k;
    bit exp_ill, exp_bus;
    int exp_done = 0;
    int done_seen = 0;

    logic [5:0] r_fn [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                              6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    logic [5:0] sh_fn [3] = '{6'h00, 6'h02, 6'h03};
    logic [5:0] ia_op [6] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f};
    logic [5:0] bad_op [4] = '{6'h3f, 6'h01, 6'h05, 6'h10};

    always #5 clk = ~clk;

    multi_cycle_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .ExtOp(ExtOp), .LuOp(LuOp),
        .state(state), .instr_done(instr_done), .illegal_op(illegal_op),
        .bus_error(bus_error)
    );

    wire [26:0] obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                       IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
                       ALUOp, PCSource, ExtOp, LuOp, instr_done, illegal_op,
                       bus_error};

    always @(negedge clk) if (instr_done) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // What the controller should drive in a given phase of the current instruction
    function automatic logic [26:0] model(input logic [2:0] ph, input bit rdy);
        bit pw = 0, pwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, rw = 0, dn = 0;
        logic [1:0] rdst = 0, m2r = 0, sa = 0, sb = 0, aop = 0, pcs = 0;
        bit ext = (OpCode != 6'h0c);
        bit lu = (OpCode == 6'h0f);
        if (ph == P_IF) begin
            mr = 1; sb = 2'b01; irw = rdy; pw = rdy;
        end else if (ph == P_ID) begin
            sb = 2'b11;
            if (cur_k == K_J || cur_k == K_JAL) begin
                pw = 1; pcs = 2'b10; dn = 1;
            end
            if (cur_k == K_JAL) begin
                rw = 1; rdst = 2'b10; m2r = 2'b10;
            end
        end else if (ph == P_EX) begin
            if (cur_k == K_R)  begin sa = 2'b01; aop = 2'b10; end
            if (cur_k == K_SH) begin sa = 2'b10; aop = 2'b10; end
            if (cur_k == K_JR || cur_k == K_JALR) begin
                pw = 1; pcs = 2'b11; dn = 1;
            end
            if (cur_k == K_JALR) begin
                rw = 1; rdst = 2'b01; m2r = 2'b10;
            end
            if (cur_k == K_BEQ) begin
                sa = 2'b01; aop = 2'b01; pwc = 1; pcs = 2'b01; dn = 1;
            end
            if (cur_k == K_IA) begin sa = 2'b01; sb = 2'b10; aop = 2'b11; end
            if (cur_k == K_LW || cur_k == K_SW) begin sa = 2'b01; sb = 2'b10; end
        end else if (ph == P_MEM) begin
            iord = 1; mr = (cur_k == K_LW); mw = (cur_k == K_SW);
            dn = (cur_k == K_SW) && rdy;
        end else begin
            rw = 1; dn = 1;
            rdst = (cur_k == K_R || cur_k == K_SH) ? 2'b01 : 2'b00;
            m2r = (cur_k == K_LW) ? 2'b01 : 2'b00;
        end
        return {ph, pw, pwc, iord, mr, mw, irw, rw, rdst, m2r, sa, sb, aop, pcs,
                ext, lu, dn, exp_ill, exp_bus};
    endfunction

    // One clock of stimulus; entered and left 1 time unit after a rising edge
    task automatic step(input logic [2:0] ph, input bit rdy, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        chk(tag, {5'd0, obs}, {5'd0, model(ph, rdy)});
        @(posedge clk);
        #1;
    endtask

    task automatic encode(input int k);
        cur_k = k;
        Funct = 6'($urandom);
        case (k)
            K_R:    begin OpCode = 6'h00; Funct = r_fn[$urandom_range(0, 9)]; end
            K_SH:   begin OpCode = 6'h00; Funct = sh_fn[$urandom_range(0, 2)]; end
            K_JR:   begin OpCode = 6'h00; Funct = 6'h08; end
            K_JALR: begin OpCode = 6'h00; Funct = 6'h09; end
            K_BEQ:  OpCode = 6'h04;
            K_J:    OpCode = 6'h02;
            K_JAL:  OpCode = 6'h03;
            K_IA:   OpCode = ia_op[$urandom_range(0, 5)];
            K_LW:   OpCode = 6'h23;
            K_SW:   OpCode = 6'h2b;
            default: OpCode = bad_op[$urandom_range(0, 3)];
        endcase
    endtask

    task automatic run_instr(input int k, input int ifw, input int mw,
                             input bit if_to, input bit mem_to);
        encode(k);
        if (if_to) begin
            for (int i = 0; i < TO; i++) step(P_IF, 1'b0, "if_to");
            exp_bus = 1;
        end
        for (int i = 0; i < ifw; i++) step(P_IF, 1'b0, "if_wait");
        step(P_IF, 1'b1, "if");
        step(P_ID, 1'($urandom), "id");
        if (k == K_J || k == K_JAL) begin exp_done++; return; end
        if (k == K_BAD) begin exp_ill = 1; return; end
        step(P_EX, 1'($urandom), "ex");
        if (k == K_JR || k == K_JALR || k == K_BEQ) begin exp_done++; return; end
        if (k == K_LW || k == K_SW) begin
            if (mem_to) begin
                for (int i = 0; i < TO; i++) step(P_MEM, 1'b0, "mem_to");
                exp_bus = 1;
                return;
            end
            for (int i = 0; i < mw; i++) step(P_MEM, 1'b0, "mem_wait");
            step(P_MEM, 1'b1, "mem");
            if (k == K_SW) begin exp_done++; return; end
        end
        step(P_WB, 1'($urandom), "wb");
        exp_done++;
    endtask

    initial begin
        reset = 1'b1; OpCode = 6'h00; Funct = 6'h20; mem_ready = 1'b1;
        exp_ill = 0; exp_bus = 0; cur_k = K_R;
        #3;
        chk("reset_outputs", {5'd0, obs}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(K_R, 0, 0, 0, 0);
        run_instr(K_LW, 0, 3, 0, 0);
        run_instr(K_BEQ, 1, 0, 0, 0);
        run_instr(K_JAL, 0, 0, 0, 0);
        run_instr(K_BAD, 0, 0, 0, 0);
        run_instr(K_R, 2, 0, 0, 0);
        run_instr(K_SW, 0, 0, 0, 1);
        run_instr(K_J, 0, 0, 1, 0);

        // Asynchronous reset in the middle of a load's memory phase
        encode(K_LW);
        step(P_IF, 1'b1, "rst_if");
        step(P_ID, 1'b0, "rst_id");
        step(P_EX, 1'b0, "rst_ex");
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("reset_async", {5'd0, obs}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ill = 0; exp_bus = 0;
        run_instr(K_SW, 1, 2, 0, 0);

        for (int n = 0; n < 150; n++) begin
            int k, ifw, mw;
            bit to;
            k   = $urandom_range(0, 10);
            ifw = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            mw  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
            to  = ($urandom_range(0, 9) == 0);
            run_instr(k, ifw, mw, 1'b0, to);
        end

        @(negedge clk);
        chk("done_count", done_seen, exp_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
